// File: rtl/move_stack_pkg.sv
// Shared move definitions for the solver path buffer and the display stage:
// the fixed move codes and the inverse-move helper.
package move_stack_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } move_e;

  // Opposite moves differ only in bit 0 (UP<->DOWN, LEFT<->RIGHT).
  function automatic move_e inverse(input move_e m);
    return move_e'(m ^ 2'b01);
  endfunction

endpackage

// File: rtl/move_stack_if.sv
// Solver/display-facing bundle of the move stack: push/pop handshake in,
// frozen path presentation out.
interface move_stack_if;

  logic                  clr;
  logic                  push_valid;
  move_stack_pkg::move_e push_dir;
  logic                  push_ready;
  logic                  pop;
  logic                  solved;
  logic                  comp;
  logic [63:0]           cnt;
  logic [63:0]           ord;
  move_stack_pkg::move_e top_dir;
  logic                  empty;
  logic                  full;
  logic                  rej;

  modport master (
    output clr, push_valid, push_dir, pop, solved,
    input  push_ready, comp, cnt, ord, top_dir, empty, full, rej
  );

  modport slave (
    input  clr, push_valid, push_dir, pop, solved,
    output push_ready, comp, cnt, ord, top_dir, empty, full, rej
  );

endinterface

// File: rtl/move_stack.sv
// LIFO solution-path buffer: push/undo moves during SEARCH, reject moves that
// cancel their predecessor, freeze the packed path in DONE until cleared.
module move_stack
  import move_stack_pkg::*;
#(
  parameter int MAX_MOVES = 31
) (
  input logic        clk,
  input logic        rst_n,
  move_stack_if.slave bus
);

  typedef enum logic {SEARCH, DONE} state_e;

  localparam logic [5:0] MAX_CNT = 6'(MAX_MOVES);

  state_e      state_q, state_d;
  logic [5:0]  cnt_q,   cnt_d;
  logic [63:0] ord_q,   ord_d;
  logic        rej_q,   rej_d;

  logic        empty, full;
  logic [4:0]  push_slot, top_slot, below_slot;
  move_e       top_dir, below_dir;

  // Slots are 5 bits so cnt=32 wraps to slot 0 and every part-select stays in range.
  assign push_slot  = cnt_q[4:0];
  assign top_slot   = push_slot - 5'd1;
  assign below_slot = push_slot - 5'd2;

  assign empty     = (cnt_q == 6'd0);
  assign full      = (cnt_q == MAX_CNT);
  assign top_dir   = empty ? UP : move_e'(ord_q[{top_slot, 1'b0} +: 2]);
  assign below_dir = move_e'(ord_q[{below_slot, 1'b0} +: 2]);

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path through
    // the decision tree leaves one unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    ord_d   = ord_q;
    rej_d   = 1'b0;

    if (bus.clr) begin
      state_d = SEARCH;
      cnt_d   = '0;
      ord_d   = '0;
    end else if (state_q == SEARCH) begin
      if (bus.push_valid && (!bus.pop || empty)) begin
        if (!full && (empty || bus.push_dir != inverse(top_dir))) begin
          ord_d[{push_slot, 1'b0} +: 2] = bus.push_dir;
          cnt_d = cnt_q + 6'd1;
        end else begin
          rej_d = 1'b1;
        end
      end else if (bus.push_valid) begin
        // Replace top: legality is judged against the entry underneath.
        if (cnt_q == 6'd1 || bus.push_dir != inverse(below_dir)) begin
          ord_d[{top_slot, 1'b0} +: 2] = bus.push_dir;
        end else begin
          rej_d = 1'b1;
        end
      end else if (bus.pop) begin
        if (!empty) begin
          ord_d[{top_slot, 1'b0} +: 2] = 2'b00;
          cnt_d = cnt_q - 6'd1;
        end else begin
          rej_d = 1'b1;
        end
      end

      if (bus.solved) state_d = DONE;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SEARCH;
      cnt_q   <= '0;
      ord_q   <= '0;
      rej_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ord_q   <= ord_d;
      rej_q   <= rej_d;
    end
  end

  assign bus.push_ready = (state_q == SEARCH) && !bus.clr && !full;
  assign bus.comp       = (state_q == DONE);
  assign bus.cnt        = {58'd0, cnt_q};
  assign bus.ord        = ord_q;
  assign bus.top_dir    = top_dir;
  assign bus.empty      = empty;
  assign bus.full       = full;
  assign bus.rej        = rej_q;

endmodule

// File: doc/move_stack.md
# move_stack

Solution-path buffer between the puzzle search engine and the display/button front end. Records the move sequence as a LIFO stack so the depth-first solver can push and undo (pop) moves. Rejects moves that immediately cancel the previous one. On `solved`, freezes the path and presents it as `comp`/`cnt`/`ord` to the display stage.

## Interface
- `MAX_MOVES`, default 31: stack capacity. Range 1..32. The default keeps `cnt` within the display's 0..31 range.
- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low
- `clr`  in  1  start a new search; empties the stack and returns to SEARCH
- `push_valid`  in  1  solver offers a move
- `push_dir`  in  2  move code: UP, DOWN, LEFT or RIGHT
- `push_ready`  out  1  a push will be accepted this cycle (combinational)
- `pop`  in  1  undo the top move
- `solved`  in  1  single-cycle pulse: the current path reaches the goal
- `comp`  out  1  path complete and frozen
- `cnt`  out  64  number of stored moves; bits 63:6 always 0
- `ord`  out  64  packed path: move i at `ord[2i+1:2i]`, move 0 is the first move; unused fields are 0
- `top_dir`  out  2  code at the top of the stack; 0 when empty
- `empty`  out  1  `cnt == 0`
- `full`  out  1  `cnt == MAX_MOVES`
- `rej`  out  1  single-cycle pulse: the last push or pop was refused

## Operation
- Move codes are fixed: UP=0, DOWN=1, LEFT=2, RIGHT=3. The inverse of a move is `code ^ 1`.
- FSM has two states.
  - SEARCH (reset state): push and pop are accepted.
  - DONE: `comp=1`; push and pop are ignored, `rej` stays 0, and `ord`/`cnt` are held.
- Transitions:
  - SEARCH → DONE when `solved=1`.
  - Any state → SEARCH when `clr=1`.
- Priority, highest first: `rst_n` low, then `clr`, then `solved`, then push/pop.
- `clr` result: `cnt=0`, `ord=0`, `comp=0`. A push or pop in the same cycle as `clr` is discarded.
- Push only (SEARCH, `push_valid`, no `pop`):
  - Accepted when `!full` and (`empty` or `push_dir != top_dir^1`).
  - On accept: `ord[2*cnt+1:2*cnt] <= push_dir` and `cnt <= cnt+1`.
  - Otherwise the stack is unchanged and `rej` pulses.
- Pop only:
  - When `!empty`: clear the top field to 0 and `cnt <= cnt-1`.
  - When empty: `rej` pulses and nothing else changes.
- Push and pop together (replace top):
  - When empty: treat as a push only.
  - Otherwise the top field is overwritten with `push_dir` and `cnt` is unchanged.
  - The inverse check is made against the entry below the top; when `cnt==1` there is no check.
  - Allowed even when `full`.
  - If the check fails, nothing changes and `rej` pulses.
- `push_ready = (state==SEARCH) && !clr && !full`. The inverse check does not affect `push_ready`; an illegal push is visible only through `rej`.
- `solved` together with a push: the push is evaluated first (accept or reject as normal), then DONE is entered. The accepted move is part of the frozen path.

## Timing
- Reset values: `comp=0`, `cnt=0`, `ord=0`, `top_dir=0`, `empty=1`, `full=0`, `rej=0`, state=SEARCH.
- All outputs except `push_ready` are registered.
- Latency: a push/pop/`solved`/`clr` at edge N is reflected on `cnt`, `ord`, `comp`, `top_dir` and `rej` after edge N.
- `rej` is high for exactly one cycle per refused operation.
- Back-to-back pushes are sustained at one per cycle until `full`.
- The display stage samples `comp`/`cnt`/`ord` asynchronously to its own divided tick. Therefore `ord` must be stable whenever `comp=1`; only `clr` or `rst_n` may change it.
- Reset mid-search discards the whole path in one cycle.

## Structure
- The move codes (UP/DOWN/LEFT/RIGHT) and the inverse function belong in the shared header `def.h`, which the display stage also uses.
- The FSM state encoding stays local to the block.
- No sub-module is needed. The 2-bit field write and clear is done with indexed part-select on a 64-bit register.
- `top_dir` and the below-top entry are read with indexed part-select using `cnt-1` and `cnt-2`.

## Test plan
- Reset, then push RIGHT, DOWN, LEFT on consecutive cycles → `cnt=3`, `ord=64'h27`, `top_dir=LEFT`, `rej=0`.
- With top=RIGHT, push LEFT → `rej` pulses once; `cnt` and `ord` unchanged. Then push UP → accepted, `cnt` increments.
- Push 31 alternating UP/LEFT moves → `full=1` and `push_ready=0`. A 32nd push → `rej`, `cnt` stays 31. Push+pop together → top replaced, `cnt=31`.
- From `cnt=2`, pop three times → `cnt` goes 1 then 0; the third pop pulses `rej`; the cleared fields read 0 and `empty=1`.
- Push DOWN in the same cycle as `solved` → `comp=1`, `cnt` includes DOWN. Later push and pop → ignored, `ord` frozen, `rej=0`.
- In DONE, assert `clr` together with a push → `comp=0`, `cnt=0`, `ord=0`, push discarded. Assert `rst_n` low mid-search → all outputs return to their reset values.
